// File: rtl/cpu_fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch front end.
package cpu_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR    = 32'hFFFF0000;
  localparam int          DEFAULT_QUEUE_DEPTH     = 4;
  localparam int          DEFAULT_MAX_OUTSTANDING = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // One extra bit so a counter can hold the value "depth" itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int QCNT_W    = cnt_width(DEFAULT_QUEUE_DEPTH);
  localparam int OUTST_W   = cnt_width(DEFAULT_QUEUE_DEPTH);
  localparam int DISCARD_W = cnt_width(DEFAULT_QUEUE_DEPTH);

endpackage

// File: rtl/cpu_fetch_queue.sv
// Power-of-two synchronous FIFO of fetched words; flush beats push and pop.
module cpu_fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage carries no reset; empty_o qualifies the head.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cpu_fetch.sv
// Fetch front end: PC sequencing, credit-limited bus requests, stale-response
// discard after redirects, and a queue feeding decode.
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR    = DEFAULT_RESET_VECTOR,
  parameter int          QUEUE_DEPTH     = DEFAULT_QUEUE_DEPTH,
  parameter int          MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p3_jump,
  input  logic [31:0] p3_jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int                CNT_W  = cnt_width(QUEUE_DEPTH);
  localparam logic [CNT_W:0]    QD_LIM = (CNT_W+1)'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0]  MO_LIM = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target_aligned;
  logic [CNT_W-1:0] outst_q, outst_d, discard_q, discard_d;
  logic             run_q;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W:0]   credit_used;
  logic             q_full, q_empty, fire, q_push;
  fetch_entry_t     q_head;

  // Handshakes: a bus request transfers when imem_req & imem_ack, and imem_addr
  // holds until then unless a redirect abandons it; a decode transfer happens
  // when out_valid & out_ready; responses need no ready since credit reserves a slot.
  assign target_aligned = p3_jump_target & ~32'h3;
  assign credit_used    = {1'b0, q_count} + {1'b0, outst_q};
  assign imem_req       = run_q & ~p3_jump & (credit_used < QD_LIM) & (outst_q < MO_LIM);
  assign imem_addr      = fetch_pc_q;
  assign fire           = imem_req & imem_ack;
  assign q_push         = imem_rsp_valid & (discard_q == '0) & ~p3_jump
                        & (~q_full | (out_ready & ~q_empty));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    discard_d  = discard_q;
    outst_d    = outst_q + CNT_W'(fire) - CNT_W'(imem_rsp_valid);
    if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (p3_jump) begin
      fetch_pc_d = target_aligned;
      rsp_pc_d   = target_aligned;
      discard_d  = outst_d;
    end else if (imem_rsp_valid) begin
      if (discard_q != '0) discard_d = discard_q - CNT_W'(1);
      else                 rsp_pc_d  = rsp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR;
      outst_q    <= '0;
      discard_q  <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      run_q      <= 1'b1;
    end
  end

  cpu_fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk_i       (clock),
    .rst_ni      (reset),
    .flush_i     (p3_jump),
    .push_i      (q_push),
    .push_data_i ('{pc: rsp_pc_q, instr: imem_rsp_data}),
    .pop_i       (out_ready),
    .head_o      (q_head),
    .count_o     (q_count),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  assign out_valid = ~q_empty;
  assign out_instr = q_empty ? 32'h0 : q_head.instr;
  assign out_pc    = q_empty ? rsp_pc_q : q_head.pc;

endmodule

// File: tb/tb_cpu_fetch.sv
// Randomized bench for cpu_fetch against a queue-based model of the fetch stream.
module tb_cpu_fetch;

  localparam logic [31:0] RV = 32'hFFFF0000;
  localparam int          QD = 4;
  localparam int          MO = 4;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } bus_req_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        p3_jump = 1'b0;
  logic [31:0] p3_jump_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  bus_req_t    pend[$];
  logic [31:0] exp_fetch;
  logic [31:0] targets [4];

  // clock/reset block
  always #5 clock = ~clock;

  cpu_fetch #(.RESET_VECTOR(RV), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)) dut (
    .clock          (clock),
    .reset          (reset),
    .p3_jump        (p3_jump),
    .p3_jump_target (p3_jump_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory content is a fixed hash of the address, so a wrong-path word is recognisable.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    p3_jump        = 1'b0;
    imem_ack       = 1'b0;
    imem_rsp_valid = 1'b0;
    out_ready      = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_imem_req",  imem_req,  32'd0);
    check_eq("rst_imem_addr", imem_addr, RV);
    check_eq("rst_out_valid", out_valid, 32'd0);
    check_eq("rst_out_instr", out_instr, 32'd0);
    check_eq("rst_out_pc",    out_pc,    RV);
    pend.delete();
    exp_q.delete();
    exp_fetch = RV;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_cycles(input int n, input int ack_pct, input int rsp_pct,
                            input int rdy_pct, input int jmp_pct,
                            input bit jump_first, input logic [31:0] first_tgt);
    for (int c = 0; c < n; c++) begin
      bit          jmp, pop, fire, exp_req;
      logic [31:0] tgt;
      bus_req_t    r;
      @(negedge clock);
      jmp = (jump_first && c == 0) || ($urandom_range(99) < jmp_pct);
      if (jump_first && c == 0)     tgt = first_tgt;
      else if ($urandom_range(1) == 1) tgt = targets[$urandom_range(3)];
      else                          tgt = $urandom();
      p3_jump        = jmp;
      p3_jump_target = tgt;
      imem_ack       = ($urandom_range(99) < ack_pct);
      imem_rsp_valid = (pend.size() > 0) && ($urandom_range(99) < rsp_pct);
      imem_rsp_data  = imem_rsp_valid ? word_at(pend[0].addr) : $urandom();
      out_ready      = ($urandom_range(99) < rdy_pct);
      #1;
      exp_req = !jmp && (exp_q.size() + pend.size() < QD) && (pend.size() < MO);
      check_eq("out_valid", out_valid, (exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check_eq("out_pc",    out_pc,    exp_q[0][63:32]);
        check_eq("out_instr", out_instr, exp_q[0][31:0]);
      end
      check_eq("imem_req", imem_req, exp_req);
      if (exp_req) check_eq("imem_addr", imem_addr, exp_fetch);

      // model advances to the next rising edge
      pop  = out_ready && (exp_q.size() > 0);
      fire = exp_req && imem_ack;
      if (pop && !jmp) void'(exp_q.pop_front());
      if (imem_rsp_valid) begin
        r = pend.pop_front();
        if (!r.stale && !jmp) exp_q.push_back({r.addr, word_at(r.addr)});
      end
      if (jmp) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        exp_q.delete();
        exp_fetch = {tgt[31:2], 2'b00};
      end
      if (fire) begin
        pend.push_back('{addr: exp_fetch, stale: 1'b0});
        exp_fetch = exp_fetch + 32'd4;
      end
    end
  endtask

  initial begin
    targets[0] = 32'h00001002;
    targets[1] = 32'hFFFFFFF6;
    targets[2] = 32'h00000000;
    targets[3] = 32'h80000101;
    exp_fetch  = RV;

    apply_reset();
    run_cycles(40,  100, 100, 100, 0, 1'b0, 32'h0);          // full rate, latency 1
    run_cycles(20,  100, 100, 0,   0, 1'b0, 32'h0);          // decode stall
    run_cycles(20,  100, 100, 100, 0, 1'b0, 32'h0);          // drain
    run_cycles(10,  100, 0,   100, 0, 1'b0, 32'h0);          // build outstanding
    run_cycles(30,  100, 20,  100, 0, 1'b1, 32'h00001002);   // redirect with stale in flight
    run_cycles(40,  100, 100, 100, 0, 1'b1, 32'hFFFFFFEE);   // address wrap
    run_cycles(300, 70,  50,  70,  8, 1'b0, 32'h0);          // mixed random
    run_cycles(40,  100, 100, 100, 30, 1'b0, 32'h0);         // dense redirects
    run_cycles(6,   100, 0,   100, 0, 1'b0, 32'h0);
    apply_reset();                                           // mid-stream reset
    run_cycles(200, 80,  60,  60,  6, 1'b0, 32'h0);
    run_cycles(20,  100, 100, 100, 0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
